arb_requester: RTL and testbench

- Client-side agent for the three-way request/grant arbiter. One instance drives one `req` line and watches its matching `g*` line.
- Queues burst commands from local logic, raises `req`, waits for grant, and holds the bus for the commanded number of granted beats.
- Releases `req` for exactly one cycle between bursts, which gives the arbiter a visible release point.
- Flags a grant timeout and retries the same command.

---
 rtl/arb_requester.sv | 121 ++++++++++++
 tb/tb_arb_requester.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arb_requester.sv
// arb_requester: client-side agent that queues burst commands, requests the bus,
// holds it for the granted beats, releases for one cycle, and retries on grant timeout.
module arb_requester #(
    parameter int DEPTH   = 4,
    parameter int LEN_W   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    input  logic [LEN_W-1:0]       cmd_len,
    output logic                   cmd_ready,
    output logic [$clog2(DEPTH):0] fifo_count,
    input  logic                   gnt,
    output logic                   req,
    output logic                   xfer_beat,
    output logic                   done,
    output logic                   timeout_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, XFER, REL} state_t;

    state_t           r_state, w_state_nxt;
    logic [LEN_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [LEN_W-1:0] r_cur_len, w_cur_len_nxt;
    logic [LEN_W-1:0] r_beat_cnt, w_beat_nxt;
    logic [WW-1:0]    r_wait_cnt, w_wait_nxt;
    logic             r_retry, w_retry_nxt;
    logic             w_push, w_pop, w_empty;

    assign cmd_ready   = r_count != CW'(DEPTH);
    assign fifo_count  = r_count;
    assign w_empty     = r_count == '0;
    assign w_push      = cmd_valid && cmd_ready;
    assign req         = (r_state == REQ) || (r_state == XFER);
    assign xfer_beat   = (r_state == XFER) && gnt;
    assign done        = (r_state == REL) && !r_retry;
    assign timeout_err = (r_state == REL) && r_retry;

    always_comb begin
        w_state_nxt   = r_state;
        w_cur_len_nxt = r_cur_len;
        w_beat_nxt    = r_beat_cnt;
        w_wait_nxt    = r_wait_cnt;
        w_retry_nxt   = r_retry;
        w_pop         = 1'b0;
        case (r_state)
            IDLE: if (!w_empty) begin
                w_pop         = 1'b1;
                w_cur_len_nxt = r_mem[r_rd_ptr];
                w_beat_nxt    = '0;
                w_wait_nxt    = '0;
                w_state_nxt   = REQ;
            end
            REQ: if (gnt) begin
                w_beat_nxt  = '0;
                w_state_nxt = XFER;
            end else begin
                w_wait_nxt = r_wait_cnt + WW'(1);
                if (r_wait_cnt == WW'(TIMEOUT - 1)) begin
                    w_retry_nxt = 1'b1;
                    w_state_nxt = REL;
                end
            end
            // Terminal compare precedes the increment, so beat_cnt never wraps.
            XFER: if (gnt) begin
                if (r_beat_cnt == r_cur_len) begin
                    w_retry_nxt = 1'b0;
                    w_state_nxt = REL;
                end else begin
                    w_beat_nxt = r_beat_cnt + LEN_W'(1);
                end
            end
            REL: if (r_retry) begin
                w_beat_nxt  = '0;
                w_wait_nxt  = '0;
                w_state_nxt = REQ;
            end else if (!w_empty) begin
                w_pop         = 1'b1;
                w_cur_len_nxt = r_mem[r_rd_ptr];
                w_beat_nxt    = '0;
                w_wait_nxt    = '0;
                w_state_nxt   = REQ;
            end else begin
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cur_len  <= '0;
            r_beat_cnt <= '0;
            r_wait_cnt <= '0;
            r_retry    <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cur_len  <= w_cur_len_nxt;
            r_beat_cnt <= w_beat_nxt;
            r_wait_cnt <= w_wait_nxt;
            r_retry    <= w_retry_nxt;
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count    <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= cmd_len;
    end
endmodule

// File: tb/tb_arb_requester.sv
// tb_arb_requester: directed scenarios plus randomized traffic checked against
// a transaction-level model of the requester.
module tb_arb_requester;
    localparam int DEPTH = 4, LEN_W = 4, TIMEOUT = 15, CW = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             cmd_valid = 1'b0;
    logic [LEN_W-1:0] cmd_len = '0;
    logic             gnt = 1'b0;
    logic             cmd_ready, req, xfer_beat, done, timeout_err;
    logic [CW-1:0]    fifo_count;
    int               vectors = 0;
    int               miscompares = 0;

    // Model: pending commands, whether a command is owned, whether it is in its
    // data phase, and whether a one-cycle release (normal or timeout) is pending.
    int m_q[$];
    bit m_busy, m_data, m_gap, m_gap_to;
    int m_cur, m_beats, m_waited;

    always #5 clk = ~clk;

    arb_requester #(.DEPTH(DEPTH), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_len(cmd_len),
        .cmd_ready(cmd_ready), .fifo_count(fifo_count), .gnt(gnt), .req(req),
        .xfer_beat(xfer_beat), .done(done), .timeout_err(timeout_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        tick();
        reset = 1'b1;
        cmd_valid = 1'b0;
        cmd_len = '0;
        gnt = 1'b0;
        m_q.delete();
        m_busy = 0; m_data = 0; m_gap = 0; m_gap_to = 0;
        m_cur = 0; m_beats = 0; m_waited = 0;
        #3;
        reset = 1'b0;
    endtask

    task automatic model_edge(input bit v, input int len, input bit g);
        bit pushok;
        pushok = v && (m_q.size() < DEPTH);
        if (m_gap) begin
            m_gap = 0;
            if (m_gap_to) begin
                m_waited = 0;
                m_data = 0;
            end else if (m_q.size() > 0) begin
                m_cur = m_q.pop_front();
                m_waited = 0;
                m_data = 0;
            end else begin
                m_busy = 0;
            end
        end else if (!m_busy) begin
            if (m_q.size() > 0) begin
                m_cur = m_q.pop_front();
                m_busy = 1; m_data = 0; m_waited = 0;
            end
        end else if (!m_data) begin
            if (g) begin
                m_data = 1;
                m_beats = 0;
            end else begin
                m_waited = m_waited + 1;
                if (m_waited == TIMEOUT) begin m_gap = 1; m_gap_to = 1; end
            end
        end else if (g) begin
            m_beats = m_beats + 1;
            if (m_beats == m_cur + 1) begin m_gap = 1; m_gap_to = 0; m_data = 0; end
        end
        if (pushok) m_q.push_back(len);
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #1;
        vectors++;
        if ({req, xfer_beat, done, timeout_err, cmd_ready, fifo_count} !== {5'b00001, CW'(0)}) begin
            miscompares++;
            $display("FAIL reset_state: got %b want %b", {req, xfer_beat, done, timeout_err, cmd_ready, fifo_count}, {5'b00001, CW'(0)});
        end
        tick();
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if ({req, cmd_ready, fifo_count} !== {2'b01, CW'(0)}) begin
            miscompares++;
            $display("FAIL reset_release: got %b want %b", {req, cmd_ready, fifo_count}, {2'b01, CW'(0)});
        end
    endtask

    task automatic test_single();
        logic [2:0] exp;
        apply_reset();
        for (int c = 0; c < 11; c++) begin
            cmd_valid = (c == 0);
            cmd_len = LEN_W'(2);
            gnt = (c >= 3);
            @(negedge clk);
            exp = {c >= 2 && c <= 6, c >= 4 && c <= 6, c == 7};
            vectors++;
            if ({req, xfer_beat, done} !== exp) begin
                miscompares++;
                $display("FAIL single c=%0d: req/xfer/done got %b want %b", c, {req, xfer_beat, done}, exp);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int lens[3] = '{0, 1, 3};
        int got[$];
        int beats = 0, low = 0;
        bit seen_hi = 0;
        apply_reset();
        for (int c = 0; c < 30; c++) begin
            cmd_valid = (c < 3);
            if (c < 3) cmd_len = LEN_W'(lens[c]);
            gnt = req;
            @(negedge clk);
            if (xfer_beat) beats++;
            if (done) begin got.push_back(beats); beats = 0; end
            if (req && seen_hi && low > 0) begin
                vectors++;
                if (low != 1) begin
                    miscompares++;
                    $display("FAIL b2b_gap: req low %0d cycles want 1", low);
                end
            end
            if (req) begin seen_hi = 1; low = 0; end
            else if (seen_hi) low++;
            tick();
        end
        cmd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (got.size() <= i || got[i] != lens[i] + 1) begin
                miscompares++;
                $display("FAIL b2b_burst%0d: got %0d beats (bursts seen %0d) want %0d", i, (got.size() > i) ? got[i] : -1, got.size(), lens[i] + 1);
            end
        end
        vectors++;
        if (got.size() != 3 || fifo_count !== CW'(0)) begin
            miscompares++;
            $display("FAIL b2b_end: dones %0d count %0d want 3 and 0", got.size(), fifo_count);
        end
    endtask

    task automatic test_fifo_full();
        int exp_cnt[7] = '{0, 1, 1, 2, 3, 4, 4};
        int got[$];
        int beats = 0;
        apply_reset();
        for (int c = 0; c < 7; c++) begin
            cmd_valid = (c < 6);
            cmd_len = LEN_W'(c);
            gnt = 1'b0;
            @(negedge clk);
            vectors++;
            if ({fifo_count, cmd_ready} !== {CW'(exp_cnt[c]), exp_cnt[c] != DEPTH}) begin
                miscompares++;
                $display("FAIL full c=%0d: count/ready got %0d/%b want %0d/%b", c, fifo_count, cmd_ready, exp_cnt[c], exp_cnt[c] != DEPTH);
            end
            tick();
        end
        cmd_valid = 1'b0;
        for (int c = 0; c < 200 && got.size() < 5; c++) begin
            gnt = req;
            @(negedge clk);
            if (xfer_beat) beats++;
            if (done) begin got.push_back(beats); beats = 0; end
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (got.size() <= i || got[i] != i + 1) begin
                miscompares++;
                $display("FAIL full_drain%0d: got %0d beats want %0d", i, (got.size() > i) ? got[i] : -1, i + 1);
            end
        end
    endtask

    task automatic test_timeout();
        int hi = 0, beats = 0, dones = 0, late = 0;
        bit seen = 0;
        apply_reset();
        cmd_valid = 1'b1;
        cmd_len = LEN_W'(1);
        tick();
        cmd_valid = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (timeout_err) begin
                seen = 1;
                vectors++;
                if (req !== 1'b0 || done !== 1'b0 || hi != TIMEOUT) begin
                    miscompares++;
                    $display("FAIL timeout_pulse: req %b done %b req-high %0d want 0 0 %0d", req, done, hi, TIMEOUT);
                end
            end else if (req) hi++;
            tick();
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL timeout_seen: no timeout_err within 40 cycles, req-high %0d", hi);
        end
        gnt = 1'b1;
        @(negedge clk);
        vectors++;
        if (req !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_retry_req: got %b want 1", req);
        end
        tick();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            beats += int'(xfer_beat);
            dones += int'(done);
            if (dones > 0 && req) late++;
            tick();
        end
        vectors++;
        if (beats != 2 || dones != 1 || late != 0 || fifo_count !== CW'(0)) begin
            miscompares++;
            $display("FAIL timeout_retry: beats %0d dones %0d req-after-done %0d count %0d want 2 1 0 0", beats, dones, late, fifo_count);
        end
    endtask

    task automatic test_preempt();
        bit pat[6] = '{1, 1, 0, 0, 1, 1};
        apply_reset();
        cmd_valid = 1'b1;
        cmd_len = LEN_W'(3);
        tick();
        cmd_valid = 1'b0;
        tick();
        gnt = 1'b1;
        @(negedge clk);
        vectors++;
        if (req !== 1'b1) begin
            miscompares++;
            $display("FAIL preempt_req: got %b want 1", req);
        end
        tick();
        for (int i = 0; i < 6; i++) begin
            gnt = pat[i];
            @(negedge clk);
            vectors++;
            if ({req, xfer_beat, done} !== {1'b1, pat[i], 1'b0}) begin
                miscompares++;
                $display("FAIL preempt i=%0d: req/xfer/done got %b want %b", i, {req, xfer_beat, done}, {1'b1, pat[i], 1'b0});
            end
            tick();
        end
        gnt = 1'b0;
        @(negedge clk);
        vectors++;
        if ({req, done} !== 2'b01) begin
            miscompares++;
            $display("FAIL preempt_done: req/done got %b want 01", {req, done});
        end
    endtask

    task automatic test_async_reset();
        int bad = 0;
        apply_reset();
        for (int c = 0; c < 3; c++) begin
            cmd_valid = 1'b1;
            cmd_len = LEN_W'(3);
            tick();
        end
        cmd_valid = 1'b0;
        gnt = 1'b1;
        @(negedge clk);
        vectors++;
        if ({req, fifo_count} !== {1'b1, CW'(2)}) begin
            miscompares++;
            $display("FAIL async_setup: req/count got %b/%0d want 1/2", req, fifo_count);
        end
        tick();
        vectors++;
        if (xfer_beat !== 1'b1) begin
            miscompares++;
            $display("FAIL async_xfer: got %b want 1", xfer_beat);
        end
        #2 reset = 1'b1;
        #1;
        vectors++;
        if ({req, xfer_beat, done, cmd_ready, fifo_count} !== {4'b0001, CW'(0)}) begin
            miscompares++;
            $display("FAIL async_immediate: got %b want %b", {req, xfer_beat, done, cmd_ready, fifo_count}, {4'b0001, CW'(0)});
        end
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (req || done) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL async_after: %0d cycles with req or done want 0", bad);
        end
        tick();
        cmd_valid = 1'b1;
        cmd_len = LEN_W'(0);
        tick();
        cmd_valid = 1'b0;
        tick();
        @(negedge clk);
        vectors++;
        if (req !== 1'b1) begin
            miscompares++;
            $display("FAIL async_new_push: req got %b want 1", req);
        end
    endtask

    task automatic test_random();
        bit quiet = 0;
        logic [4+CW:0] exp;
        apply_reset();
        for (int c = 0; c < 800; c++) begin
            if (c % 40 == 0) quiet = bit'($urandom_range(0, 1));
            cmd_valid = ($urandom_range(0, 9) < 3);
            cmd_len = LEN_W'($urandom_range(0, 2 ** LEN_W - 1));
            gnt = quiet ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 9) < 7);
            @(negedge clk);
            exp = {m_busy && !m_gap, m_busy && m_data && !m_gap && gnt, m_gap && !m_gap_to,
                   m_gap && m_gap_to, m_q.size() < DEPTH, CW'(m_q.size())};
            vectors++;
            if ({req, xfer_beat, done, timeout_err, cmd_ready, fifo_count} !== exp) begin
                miscompares++;
                $display("FAIL random c=%0d: req/xfer/done/tmo/rdy/count got %b want %b", c, {req, xfer_beat, done, timeout_err, cmd_ready, fifo_count}, exp);
            end
            model_edge(cmd_valid, int'(cmd_len), gnt);
            tick();
        end
        cmd_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_fifo_full();
        test_timeout();
        test_preempt();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
